// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder: word aligner (control-token search/verify/lock) and TMDS 10b->8b decoder for one channel
module tmds_channel_decoder #(
  parameter int LOSS_LIMIT   = 4096,
  parameter int VERIFY_COUNT = 16
) (
  input  logic       pixclk,
  input  logic       reset_n,
  input  logic [9:0] raw_symbol,
  output logic [7:0] data,
  output logic [1:0] cd,
  output logic       de,
  output logic       locked,
  output logic [3:0] align_offset
);
  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t      state_q, state_d;
  logic [9:0]  r0_q, r1_q, sym_q, cand;
  logic [19:0] win;
  logic [3:0]  off_q, off_d, align_q, align_d, hit_k;
  logic [4:0]  vcnt_q, vcnt_d;
  logic [12:0] loss_q, loss_d;
  logic [7:0]  data_q, data_d, d, x, dec;
  logic [1:0]  cd_q, cd_d;
  logic        de_q, de_d, locked_q, hit, tok_at, sym_tok, live;

  function automatic logic is_tok(input logic [9:0] s);
    return s == 10'h354 || s == 10'h0AB || s == 10'h154 || s == 10'h2AB;
  endfunction

  function automatic logic [1:0] tok_cd(input logic [9:0] s);
    return s == 10'h0AB ? 2'b01 : s == 10'h154 ? 2'b10 : s == 10'h2AB ? 2'b11 : 2'b00;
  endfunction

  assign win  = {r0_q, r1_q};
  assign cand = 10'(win >> off_q);

  // lowest bit offset at which the window holds a control token
  always_comb begin
    hit   = 1'b0;
    hit_k = '0;
    for (int k = 9; k >= 0; k--) begin
      if (is_tok(win[k +: 10])) begin
        hit   = 1'b1;
        hit_k = 4'(k);
      end
    end
  end

  // alignment state machine: search, verify consecutive tokens, hold lock until tokens go missing
  always_comb begin
    tok_at  = is_tok(cand);
    state_d = state_q;
    off_d   = off_q;
    vcnt_d  = vcnt_q;
    loss_d  = '0;
    unique case (state_q)
      SEARCH: if (hit) begin
        off_d   = hit_k;
        vcnt_d  = 5'd1;
        state_d = VERIFY;
      end
      VERIFY: if (tok_at) begin
        vcnt_d  = vcnt_q + 5'd1;
        state_d = 32'(vcnt_d) >= VERIFY_COUNT ? LOCKED : VERIFY;
      end else begin
        vcnt_d  = '0;
        state_d = SEARCH;
      end
      LOCKED: begin
        loss_d  = tok_at ? '0 : loss_q == '1 ? loss_q : loss_q + 13'd1;
        state_d = 32'(loss_d) >= LOSS_LIMIT ? SEARCH : LOCKED;
      end
      default: state_d = SEARCH;
    endcase
    align_d = state_d == LOCKED ? off_d : align_q;
  end

  // decode the aligned symbol; outputs are forced idle whenever the lane is not locked
  always_comb begin
    d       = sym_q[9] ? ~sym_q[7:0] : sym_q[7:0];
    x       = d ^ {d[6:0], 1'b0};
    dec     = sym_q[8] ? x : {~x[7:1], x[0]};
    sym_tok = is_tok(sym_q);
    live    = state_q == LOCKED;
    de_d    = live && !sym_tok;
    data_d  = !live ? 8'h00 : sym_tok ? data_q : dec;
    cd_d    = !live ? 2'b00 : sym_tok ? tok_cd(sym_q) : cd_q;
  end

  // pipeline, FSM and output registers
  always_ff @(posedge pixclk or negedge reset_n) begin
    if (!reset_n) begin
      r0_q     <= '0;
      r1_q     <= '0;
      sym_q    <= '0;
      state_q  <= SEARCH;
      off_q    <= '0;
      vcnt_q   <= '0;
      loss_q   <= '0;
      align_q  <= '0;
      locked_q <= 1'b0;
      data_q   <= '0;
      cd_q     <= '0;
      de_q     <= 1'b0;
    end else begin
      r0_q     <= raw_symbol;
      r1_q     <= r0_q;
      sym_q    <= cand;
      state_q  <= state_d;
      off_q    <= off_d;
      vcnt_q   <= vcnt_d;
      loss_q   <= loss_d;
      align_q  <= align_d;
      locked_q <= state_d == LOCKED;
      data_q   <= data_d;
      cd_q     <= cd_d;
      de_q     <= de_d;
    end
  end

  assign data         = data_q;
  assign cd           = cd_q;
  assign de           = de_q;
  assign locked       = locked_q;
  assign align_offset = align_q;
endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb_tmds_channel_decoder: directed table-driven checks of alignment, decode, loss of lock and reset
module tb_tmds_channel_decoder;
  logic       pixclk = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] raw_symbol = '0;
  logic [7:0] data;
  logic [1:0] cd;
  logic       de, locked;
  logic [3:0] align_offset;

  tmds_channel_decoder dut (
    .pixclk(pixclk), .reset_n(reset_n), .raw_symbol(raw_symbol),
    .data(data), .cd(cd), .de(de), .locked(locked), .align_offset(align_offset)
  );

  always #5 pixclk = ~pixclk;

  typedef struct {
    logic       tk;
    logic [9:0] sym;
    logic [7:0] data;
    logic       de;
    logic       cdv;
    logic       lk;
  } vec_t;

  vec_t tbl[28];
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   sq[$];

  function automatic logic [15:0] outs();
    return {locked, align_offset, de, cd, data};
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic restart(input int dly);
    sq.delete();
    repeat (dly) sq.push_back(1'b0);
    cyc = 0;
  endtask

  task automatic send(input logic [9:0] s);
    logic [9:0] w;
    for (int j = 0; j < 10; j++) sq.push_back(s[j]);
    for (int j = 0; j < 10; j++) w[j] = sq.pop_front();
    raw_symbol = w;
    @(posedge pixclk);
    #1;
    cyc++;
  endtask

  task automatic run_table(input int dly, input logic [9:0] tk, input logic [1:0] tcd);
    logic [15:0] exp;
    restart(dly);
    for (int i = 0; i < 28; i++) begin
      send(tbl[i].tk ? tk : tbl[i].sym);
      exp = {tbl[i].lk, tbl[i].lk ? 4'(dly) : 4'd0, tbl[i].de, tbl[i].cdv ? tcd : 2'b00, tbl[i].data};
      chk($sformatf("seq_off%0d_step%0d", dly, cyc), outs(), exp);
    end
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    @(posedge pixclk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 28; i++) begin
      tbl[i].tk   = i + 1 <= 20;
      tbl[i].sym  = i + 1 == 21 ? 10'h100 : i + 1 == 23 ? 10'h3FF : 10'h2FF;
      tbl[i].lk   = i + 1 >= 18;
      tbl[i].cdv  = i + 1 >= 19;
      tbl[i].de   = i + 1 >= 24;
      tbl[i].data = (i + 1 == 25 || i + 1 >= 27) ? 8'hFE : 8'h00;
    end
    repeat (5) begin
      raw_symbol = 10'($urandom);
      @(posedge pixclk);
      #1;
      chk("reset_hold", outs(), 16'h0000);
    end
    reset_n = 1'b1;
    run_table(0, 10'h354, 2'b00);
    while (cyc < 4119) begin
      send(10'h2FF);
      if (cyc == 4117) chk("loss_still_locked", {15'b0, locked}, 16'h0001);
      if (cyc == 4118) chk("loss_drop", outs(), {1'b0, 4'd0, 1'b1, 2'b00, 8'hFE});
      if (cyc == 4119) chk("loss_gated", outs(), 16'h0000);
    end
    pulse_reset();
    restart(0);
    for (int n = 1; n <= 28; n++) begin
      send(n == 10 ? 10'h100 : 10'h354);
      if (n == 18) chk("corrupt_no_early_lock", {15'b0, locked}, 16'h0000);
      if (n == 27) chk("corrupt_not_yet", {15'b0, locked}, 16'h0000);
      if (n == 28) chk("corrupt_relock", {15'b0, locked}, 16'h0001);
    end
    pulse_reset();
    run_table(7, 10'h154, 2'b10);
    @(negedge pixclk);
    reset_n = 1'b0;
    #1;
    chk("midlock_async_clear", outs(), 16'h0000);
    @(negedge pixclk);
    reset_n = 1'b1;
    restart(7);
    for (int n = 1; n <= 18; n++) begin
      send(10'h154);
      if (n == 17) chk("relock_not_yet", {15'b0, locked}, 16'h0000);
      if (n == 18) chk("relock_full_verify", {11'b0, locked, align_offset}, {11'b0, 1'b1, 4'd7});
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
